// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//  Front-end for the dice/traffic-light multiplexer. A raw, bouncy push-button
//  is brought into the clock domain by a two-flop synchroniser, debounced by a
//  four-state FSM, and presented as a clean level plus single-cycle press,
//  release and long-press pulses. Every long press toggles sel_out, which
//  selects between the dice (0) and the traffic lights (1).
//
// Ports
//  clk           in   rising-edge clock
//  rst           in   asynchronous, active-low reset (0 = reset)
//  button_in     in   raw asynchronous push-button level
//  button_out    out  debounced level (high in HELD and RELEASE_CHK)
//  press_pulse   out  one-cycle pulse when a press is accepted
//  release_pulse out  one-cycle pulse when a release is accepted
//  long_pulse    out  one-cycle pulse, at most once per accepted press
//  sel_out       out  toggles on every long_pulse
// ---------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LONG_CYCLES     = 16,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic button_in,
    output logic button_out,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic sel_out
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic            r_s1;
    logic            r_s2;
    state_t          r_state;
    logic [CNT_W-1:0] r_dcnt;
    logic [CNT_W-1:0] r_hcnt;
    logic            r_button_out;
    logic            r_press;
    logic            r_release;
    logic            r_long;
    logic            r_sel;

    state_t          w_state_nxt;
    logic [CNT_W-1:0] w_dcnt_nxt;
    logic [CNT_W-1:0] w_hcnt_nxt;
    logic            w_button_nxt;
    logic            w_press_nxt;
    logic            w_release_nxt;
    logic            w_long_nxt;
    logic            w_sel_nxt;

    // Two-flop synchroniser for the asynchronous button level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= button_in;
            r_s2 <= r_s1;
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_dcnt       <= CNT_ZERO;
            r_hcnt       <= CNT_ZERO;
            r_button_out <= 1'b0;
            r_press      <= 1'b0;
            r_release    <= 1'b0;
            r_long       <= 1'b0;
            r_sel        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_dcnt       <= w_dcnt_nxt;
            r_hcnt       <= w_hcnt_nxt;
            r_button_out <= w_button_nxt;
            r_press      <= w_press_nxt;
            r_release    <= w_release_nxt;
            r_long       <= w_long_nxt;
            r_sel        <= w_sel_nxt;
        end
    end

    // Next-state, counter and output decode; pulses default low so each
    // lasts exactly one cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_dcnt_nxt    = r_dcnt;
        w_hcnt_nxt    = r_hcnt;
        w_button_nxt  = r_button_out;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
        w_sel_nxt     = r_sel;

        case (r_state)
            IDLE: begin
                w_button_nxt = 1'b0;
                w_hcnt_nxt   = CNT_ZERO;
                if (r_s2) begin
                    w_state_nxt = PRESS_CHK;
                    w_dcnt_nxt  = CNT_ONE;
                end else begin
                    w_dcnt_nxt  = CNT_ZERO;
                end
            end

            PRESS_CHK: begin
                if (!r_s2) begin
                    // Bounce: fall back without any pulse.
                    w_state_nxt = IDLE;
                    w_dcnt_nxt  = CNT_ZERO;
                end else if (r_dcnt == DEB_LAST) begin
                    w_state_nxt  = HELD;
                    w_press_nxt  = 1'b1;
                    w_button_nxt = 1'b1;
                    w_hcnt_nxt   = CNT_ZERO;
                end else begin
                    w_dcnt_nxt = r_dcnt + CNT_ONE;
                end
            end

            HELD: begin
                if (!r_s2) begin
                    w_state_nxt = RELEASE_CHK;
                    w_dcnt_nxt  = CNT_ONE;
                end else if (r_hcnt < LONG_MAX) begin
                    // Saturating count: the long pulse fires only on the
                    // single step into LONG_CYCLES.
                    w_hcnt_nxt = r_hcnt + CNT_ONE;
                    if (r_hcnt == LONG_LAST) begin
                        w_long_nxt = 1'b1;
                        w_sel_nxt  = ~r_sel;
                    end else begin
                        w_long_nxt = 1'b0;
                    end
                end else begin
                    w_hcnt_nxt = r_hcnt;
                end
            end

            RELEASE_CHK: begin
                if (r_s2) begin
                    // Bounce: back to HELD, hcnt paused rather than cleared.
                    w_state_nxt = HELD;
                    w_dcnt_nxt  = CNT_ZERO;
                end else if (r_dcnt == DEB_LAST) begin
                    w_state_nxt   = IDLE;
                    w_release_nxt = 1'b1;
                    w_button_nxt  = 1'b0;
                    w_hcnt_nxt    = CNT_ZERO;
                end else begin
                    w_dcnt_nxt = r_dcnt + CNT_ONE;
                end
            end

            default: begin
                w_state_nxt  = IDLE;
                w_dcnt_nxt   = CNT_ZERO;
                w_hcnt_nxt   = CNT_ZERO;
                w_button_nxt = 1'b0;
            end
        endcase
    end

    assign button_out    = r_button_out;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign long_pulse    = r_long;
    assign sel_out       = r_sel;

endmodule
